// File: rtl/pc_fetch_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_gen
// Purpose  : PC generator and instruction-fetch front end. Issues sequential
//            fetch requests, pairs in-order memory responses with their PCs,
//            buffers results for decode and discards in-flight work on flush.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 'h8000_0000,
  parameter int                MAX_OUTST  = 2,
  parameter int                OBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_to_pipeline,
  input  logic [ADDR_W-1:0] flush_pc_to_pipeline,
  output logic              ifu_req_valid,
  output logic [ADDR_W-1:0] ifu_req_addr,
  input  logic              ifu_req_ready,
  input  logic              ifu_rsp_valid,
  input  logic [31:0]       ifu_rsp_data,
  input  logic              ifu_rsp_err,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic              if_err,
  input  logic              if_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam int IQ_AW = (MAX_OUTST  > 1) ? $clog2(MAX_OUTST)  : 1;
  localparam int OB_AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  // One shared counter width, wide enough to hold live_cnt + ob_cnt without wrap
  localparam int CNT_W = $clog2(MAX_OUTST + OBUF_DEPTH + 1) + 1;

  localparam logic [IQ_AW-1:0] IQ_LAST = IQ_AW'(MAX_OUTST - 1);
  localparam logic [OB_AW-1:0] OB_LAST = OB_AW'(OBUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] IQ_CAP  = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] OB_CAP  = CNT_W'(OBUF_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  logic [1:0]           state;
  logic [ADDR_W-1:0]    pc_r;

  // In-flight request queue: PC of each accepted request plus a kill flag
  logic [ADDR_W-1:0]    iq_pc [MAX_OUTST];
  logic [MAX_OUTST-1:0] iq_kill;
  logic [IQ_AW-1:0]     iq_head;
  logic [IQ_AW-1:0]     iq_tail;
  logic [CNT_W-1:0]     iq_cnt;
  // Entries in the in-flight queue that are not killed; they reserve buffer space
  logic [CNT_W-1:0]     live_cnt;

  // Output buffer toward decode
  logic [ADDR_W-1:0]    ob_pc   [OBUF_DEPTH];
  logic [31:0]          ob_data [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0] ob_err;
  logic [OB_AW-1:0]     ob_head;
  logic [OB_AW-1:0]     ob_tail;
  logic [CNT_W-1:0]     ob_cnt;

  logic req_fire;
  logic rsp_take;
  logic rsp_live;
  logic err_live;
  logic ob_pop;

  // A request is only offered when both the in-flight slots and the buffer
  // space for every live response are guaranteed, so responses never stall.
  assign ifu_req_valid = (state == ST_RUN) && !flush_to_pipeline &&
                         (iq_cnt < IQ_CAP) && ((live_cnt + ob_cnt) < OB_CAP);
  assign ifu_req_addr  = pc_r;
  assign req_fire      = ifu_req_valid && ifu_req_ready;

  // Responses with nothing outstanding (or before the first request) are dropped
  assign rsp_take = ifu_rsp_valid && (iq_cnt != '0) && (state != ST_IDLE);
  // A response arriving in the flush cycle belongs to the old stream
  assign rsp_live = rsp_take && !iq_kill[iq_head] && !flush_to_pipeline;
  assign err_live = rsp_live && ifu_rsp_err;

  assign if_valid = (ob_cnt != '0) && !flush_to_pipeline;
  assign ob_pop   = if_valid && if_ready;
  assign if_pc    = if_valid ? ob_pc[ob_head]   : '0;
  assign if_instr = if_valid ? ob_data[ob_head] : '0;
  assign if_err   = if_valid ? ob_err[ob_head]  : 1'b0;

  // Control state: one IDLE cycle after reset, RUN while fetching, HALT after a fault
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (flush_to_pipeline) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_IDLE: state <= ST_RUN;
        ST_RUN:  if (err_live) state <= ST_HALT;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Fetch PC: redirect on flush (word aligned), otherwise advance on each accept
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (flush_to_pipeline) begin
      pc_r <= flush_pc_to_pipeline & ALIGN_MASK;
    end else if (req_fire) begin
      pc_r <= pc_r + PC_STEP;
    end
  end

  // In-flight queue control; a flush or live fault kills everything still
  // outstanding, including a request accepted in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      iq_head  <= '0;
      iq_tail  <= '0;
      iq_cnt   <= '0;
      live_cnt <= '0;
      iq_kill  <= '0;
    end else begin
      if (req_fire) begin
        iq_kill[iq_tail] <= 1'b0;
        iq_tail          <= (iq_tail == IQ_LAST) ? '0 : iq_tail + 1'b1;
      end
      if (rsp_take) begin
        iq_head <= (iq_head == IQ_LAST) ? '0 : iq_head + 1'b1;
      end
      if (flush_to_pipeline || err_live) begin
        iq_kill <= '1;
      end
      iq_cnt <= iq_cnt + CNT_W'(req_fire) - CNT_W'(rsp_take);
      if (flush_to_pipeline || err_live) begin
        live_cnt <= '0;
      end else begin
        live_cnt <= live_cnt + CNT_W'(req_fire) - CNT_W'(rsp_live);
      end
    end
  end

  // In-flight PC storage (payload only, no reset needed)
  always_ff @(posedge clk) begin
    if (req_fire) begin
      iq_pc[iq_tail] <= pc_r;
    end
  end

  // Output buffer control; cleared by flush, simultaneous push/pop keeps count
  always_ff @(posedge clk) begin
    if (rst || flush_to_pipeline) begin
      ob_head <= '0;
      ob_tail <= '0;
      ob_cnt  <= '0;
    end else begin
      if (rsp_live) begin
        ob_tail <= (ob_tail == OB_LAST) ? '0 : ob_tail + 1'b1;
      end
      if (ob_pop) begin
        ob_head <= (ob_head == OB_LAST) ? '0 : ob_head + 1'b1;
      end
      ob_cnt <= ob_cnt + CNT_W'(rsp_live) - CNT_W'(ob_pop);
    end
  end

  // Output buffer payload: pair the response with the PC at the queue head
  always_ff @(posedge clk) begin
    if (rsp_live) begin
      ob_pc[ob_tail]   <= iq_pc[iq_head];
      ob_data[ob_tail] <= ifu_rsp_data;
      ob_err[ob_tail]  <= ifu_rsp_err;
    end
  end

  a_ob_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_live && !ob_pop && (ob_cnt == OB_CAP)));
  a_iq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(req_fire && !rsp_take && (iq_cnt == IQ_CAP)));

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_gen
// Purpose  : Randomized scoreboard bench for pc_fetch_gen with an in-order
//            memory model and a stream-level reference of the fetch rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_gen;

  localparam int          ADDR_W     = 32;
  localparam int          MAX_OUTST  = 2;
  localparam int          OBUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] ERR_PC     = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready = 1'b0;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_data = '0;
  logic        ifu_rsp_err = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_err;
  logic        if_ready = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_gen #(
    .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST), .OBUF_DEPTH(OBUF_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .flush_to_pipeline(flush), .flush_pc_to_pipeline(flush_pc),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_err(if_err), .if_ready(if_ready)
  );

  // Memory-side record of an accepted request
  typedef struct {
    logic [31:0] addr;   // address the memory saw
    logic [31:0] pc;     // address the reference expected
    int          epoch;  // stream generation at acceptance
    int          due;    // earliest response cycle
  } mreq_t;

  // Expected decode-side output
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
    int          vis;    // first cycle it may appear
  } exp_t;

  mreq_t       mem_q[$];
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          epoch = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          halted = 1'b0;
  int          halt_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus plus the reference model's view of it
  task automatic step(input int rdy_pct, input int ifr_pct, input bit do_flush,
                      input logic [31:0] fpc, input bit rnd);
    mreq_t rsp_m;
    mreq_t m;
    bit    got_rsp;
    bit    fl;
    bit    exp_valid;
    int    live;
    @(negedge clk);
    cyc++;
    fl = do_flush;
    if (!fl && rnd && (int'($urandom_range(0, 99)) < 2)) fl = 1'b1;
    if (!fl && halted && (halt_cnt > 8)) fl = 1'b1;
    flush         = fl;
    flush_pc      = do_flush ? fpc : $urandom;
    ifu_req_ready = (int'($urandom_range(0, 99)) < rdy_pct);
    if_ready      = (int'($urandom_range(0, 99)) < ifr_pct);
    got_rsp       = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    ifu_rsp_data  = $urandom;
    if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
      rsp_m         = mem_q.pop_front();
      got_rsp       = 1'b1;
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data  = mem_word(rsp_m.addr);
      ifu_rsp_err   = (rsp_m.addr == ERR_PC) || (rnd && ($urandom_range(0, 39) == 0));
    end
    #1;
    // Request offered iff fetching, not flushing, an in-flight slot is free
    // and every live response already has a buffer place reserved.
    live = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch == epoch) live++;
    if (got_rsp && (rsp_m.epoch == epoch)) live++;
    exp_valid = !fl && !halted && ((mem_q.size() + int'(got_rsp)) < MAX_OUTST) &&
                ((live + sb.size()) < OBUF_DEPTH);
    check("req_valid", 64'(ifu_req_valid), 64'(exp_valid));
    if (fl) begin
      epoch++;
      sb.delete();
      exp_pc   = flush_pc & ~32'h3;
      halted   = 1'b0;
      halt_cnt = 0;
    end
    if (ifu_req_valid) check("req_addr", 64'(ifu_req_addr), 64'(exp_pc));
    if (ifu_req_valid && ifu_req_ready) begin
      m.addr  = ifu_req_addr;
      m.pc    = exp_pc;
      m.epoch = epoch;
      m.due   = cyc + 1 + int'($urandom_range(0, 2));
      mem_q.push_back(m);
      exp_pc  = exp_pc + 32'd4;
    end
    if (got_rsp && (rsp_m.epoch == epoch)) begin
      sb.push_back('{pc: rsp_m.pc, instr: mem_word(rsp_m.pc), err: ifu_rsp_err, vis: cyc + 1});
      if (ifu_rsp_err) begin
        epoch++;
        halted = 1'b1;
      end
    end
    if (halted) halt_cnt++;
  endtask

  // Reset (power-on or mid-stream) and the idle cycle that follows it
  task automatic do_reset(input int n);
    @(negedge clk);
    cyc++;
    rst = 1'b1; flush = 1'b0; ifu_rsp_valid = 1'b0; ifu_req_ready = 1'b0; if_ready = 1'b0;
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    check("rst_req_valid", 64'(ifu_req_valid), 64'(0));
    check("rst_req_addr",  64'(ifu_req_addr),  64'(RESET_PC));
    check("rst_if_valid",  64'(if_valid),      64'(0));
    check("rst_if_pc",     64'(if_pc),         64'(0));
    check("rst_if_instr",  64'(if_instr),      64'(0));
    check("rst_if_err",    64'(if_err),        64'(0));
    mem_q.delete();
    sb.delete();
    epoch++;
    exp_pc = RESET_PC; halted = 1'b0; halt_cnt = 0;
    rst = 1'b0; ifu_req_ready = 1'b1; if_ready = 1'b1;
    #1;
    check("idle_no_req", 64'(ifu_req_valid), 64'(0));
  endtask

  // Monitor: pop the scoreboard on every decode handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) continue;
      if (if_valid && if_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL if_unexpected: got pc 0x%0h with nothing expected (cycle %0d)", if_pc, cyc);
        end else begin
          e = sb.pop_front();
          check("if_pc",      64'(if_pc),      64'(e.pc));
          check("if_instr",   64'(if_instr),   64'(e.instr));
          check("if_err",     64'(if_err),     64'(e.err));
          check("if_latency", 64'(cyc >= e.vis), 64'(1));
          n_out++;
        end
      end else if (!if_valid) begin
        check("if_idle_zero", 64'((if_pc == '0) && (if_instr == '0) && (if_err == 1'b0)), 64'(1));
      end
    end
  end

  int rdy_tab[8] = '{100, 70, 30, 100, 50, 90, 20, 80};
  int ifr_tab[8] = '{100, 60,  0,  30, 100, 80, 50, 10};

  initial begin
    do_reset(3);
    // Streaming from reset; the response at ERR_PC faults and halts fetch
    repeat (12) step(100, 100, 1'b0, '0, 1'b0);
    step(100, 100, 1'b1, 32'h0000_0200, 1'b0);
    repeat (10) step(100, 100, 1'b0, '0, 1'b0);
    // Flush to an unaligned target with work in flight, then decode stall
    step(100, 100, 1'b1, 32'h0000_1002, 1'b0);
    repeat (6) step(100, 0, 1'b0, '0, 1'b0);
    repeat (6) step(100, 100, 1'b0, '0, 1'b0);
    // PC wrap at the top of the address space
    step(100, 100, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (10) step(100, 100, 1'b0, '0, 1'b0);
    // Request held by a stalled memory, then redirected while held
    step(0, 100, 1'b1, 32'h0000_3000, 1'b0);
    repeat (3) step(0, 100, 1'b0, '0, 1'b0);
    step(0, 100, 1'b1, 32'h0000_4000, 1'b0);
    repeat (5) step(100, 100, 1'b0, '0, 1'b0);
    // Randomized phases with a mid-stream reset
    for (int p = 0; p < 8; p++) begin
      repeat (400) step(rdy_tab[p], ifr_tab[p], 1'b0, '0, 1'b1);
      if (p == 3) do_reset(2);
    end
    // Drain: no new requests, let outstanding responses reach decode
    repeat (20) step(0, 100, 1'b0, '0, 1'b0);
    check("sb_drained",   64'(sb.size()),  64'(0));
    check("outputs_seen", 64'(n_out > 50), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
